q_word_deserializer: RTL

Serial-to-parallel front end that builds 16-bit words for the Q-type datapath registers. It samples a framed serial stream: a start strobe, WIDTH data bits MSB first, and an optional even-parity bit. It then presents the assembled word on word_out with a one-cycle ld strobe, so the word and strobe can drive a register's reg_in/ld pair directly. Frames that fail parity raise err and leave word_out unchanged.

---
 rtl/q_word_deserializer.sv | 115 +++++++++++
 1 files changed

// File: rtl/q_word_deserializer.sv
// Serial-to-parallel front end for the Q-type datapath registers: collects a framed,
// MSB-first stream with optional even parity and emits the word with a one-cycle ld strobe.
module q_word_deserializer #(
   parameter int WIDTH     = 16,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic [WIDTH-1:0] word_out,
   output logic             ld,
   output logic             err,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_PAR  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             acc_q, acc_d;
   logic             ld_q, ld_d;
   logic             err_q, err_d;

   always_comb begin
      // NOTE: every next-state value defaults to its current value (pulses to 0) so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      acc_d   = acc_q;
      ld_d    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_DATA;
               cnt_d   = '0;
               shift_d = '0;
               acc_d   = 1'b0;
            end
         end
         S_DATA: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (bit_valid) begin
               shift_d = {shift_q[WIDTH-2:0], bit_in};
               acc_d   = acc_q ^ bit_in;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST_BIT) begin
                  if (PARITY_EN) begin
                     state_d = S_PAR;
                  end else begin
                     // Without parity the final data edge also commits the word.
                     state_d = S_DONE;
                     ld_d    = 1'b1;
                     word_d  = {shift_q[WIDTH-2:0], bit_in};
                  end
               end
            end
         end
         S_PAR: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (bit_valid) begin
               state_d = S_DONE;
               if ((acc_q ^ bit_in) == 1'b0) begin
                  ld_d   = 1'b1;
                  word_d = shift_q;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         acc_q   <= 1'b0;
         ld_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         acc_q   <= acc_d;
         ld_q    <= ld_d;
         err_q   <= err_d;
      end
   end

   assign word_out = word_q;
   assign ld       = ld_q;
   assign err      = err_q;
   assign busy     = (state_q != S_IDLE);

endmodule
